mem_port_arbiter: RTL and testbench

Shares the single data-memory port (op/addr/write_data/read_data, combinational read) between two requesters: the core load/store unit (port C) and an external loader/debug port (port E). Uses a req/gnt handshake with round-robin arbitration and returns registered read data one cycle after grant. Sits between the core/loader and the memory manager. Also reports core stall and a saturating contention count.

---
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one combinational-read data-memory port between the
// core load/store unit (port C) and the external loader/debug port (port E).
// Round-robin grant, registered read return one cycle after grant, core stall
// flag and a saturating contention counter.
// Build option: define MEM_ARB_LOCK_EN to add the e_lock input, which lets the
// external port hold priority for up to MAX_LOCK consecutive contended grants.
module mem_port_arbiter #(
    parameter int         WORD_SIZE  = 8,
    parameter logic [1:0] IDLE_OP    = 2'b00,
    parameter logic       CORE_FIRST = 1'b1,
    parameter int         MAX_LOCK   = 4,
    parameter logic [1:0] MEM_READ   = 2'b01,
    parameter logic [1:0] MEM_WRITE  = 2'b10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 c_req,
    input  logic [1:0]           c_op,
    input  logic [WORD_SIZE-1:0] c_addr,
    input  logic [WORD_SIZE-1:0] c_wdata,
    input  logic                 e_req,
    input  logic [1:0]           e_op,
    input  logic [WORD_SIZE-1:0] e_addr,
    input  logic [WORD_SIZE-1:0] e_wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic                 e_lock,
`endif
    output logic                 c_gnt,
    output logic                 e_gnt,
    output logic                 c_rvalid,
    output logic                 e_rvalid,
    output logic [WORD_SIZE-1:0] c_rdata,
    output logic [WORD_SIZE-1:0] e_rdata,
    output logic                 c_stall,
    output logic [7:0]           conflict_cnt,
    output logic [1:0]           mem_op,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    // Pointer encoding: which port won the most recent granted cycle.
    localparam logic LAST_C = 1'b1;
    localparam logic LAST_E = 1'b0;
    localparam logic LAST_RST = CORE_FIRST ? LAST_E : LAST_C;

    // An idle op equal to a real op would turn every idle cycle into an access.
    if (IDLE_OP == MEM_READ || IDLE_OP == MEM_WRITE || MAX_LOCK < 1) begin : g_bad_params
        $error("mem_port_arbiter: IDLE_OP must differ from MEM_READ/MEM_WRITE and MAX_LOCK must be >= 1");
    end

    logic                 last_q, last_d;
    logic [7:0]           conflict_cnt_q, conflict_cnt_d;
    logic                 c_rvalid_q, c_rvalid_d;
    logic                 e_rvalid_q, e_rvalid_d;
    logic [WORD_SIZE-1:0] c_rdata_q, c_rdata_d;
    logic [WORD_SIZE-1:0] e_rdata_q, e_rdata_d;
    logic                 c_win, e_win;
    logic                 both_req;

`ifdef MEM_ARB_LOCK_EN
    localparam int LW = $clog2(MAX_LOCK + 1);
    localparam logic [LW-1:0] MAX_LOCK_V = LW'(MAX_LOCK);
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
`endif

    assign both_req = c_req & e_req;

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        c_win = 1'b0;
        e_win = 1'b0;
        if (!reset) begin
            if (c_req && !e_req) begin
                c_win = 1'b1;
            end else if (e_req && !c_req) begin
                e_win = 1'b1;
            end else if (both_req) begin
`ifdef MEM_ARB_LOCK_EN
                // A full lock run forces one core grant before ext may lock again.
                if (lock_cnt_q >= MAX_LOCK_V) begin
                    c_win = 1'b1;
                end else if (lock_cnt_q != '0 && e_lock) begin
                    e_win = 1'b1;
                end else if (last_q == LAST_E) begin
                    c_win = 1'b1;
                end else begin
                    e_win = 1'b1;
                end
`else
                if (last_q == LAST_E) begin
                    c_win = 1'b1;
                end else begin
                    e_win = 1'b1;
                end
`endif
            end
        end
    end

    // Memory-side mux: granted port drives the bus, unknown ops become idle.
    always_comb begin
        mem_op    = IDLE_OP;
        mem_addr  = '0;
        mem_wdata = '0;
        if (c_win) begin
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
            if (c_op == MEM_READ || c_op == MEM_WRITE) begin
                mem_op = c_op;
            end
        end else if (e_win) begin
            mem_addr  = e_addr;
            mem_wdata = e_wdata;
            if (e_op == MEM_READ || e_op == MEM_WRITE) begin
                mem_op = e_op;
            end
        end
    end

    // Next-state: pointer, contention counter and read-return registers.
    always_comb begin
        last_d = last_q;
        if (c_win) begin
            last_d = LAST_C;
        end else if (e_win) begin
            last_d = LAST_E;
        end

        conflict_cnt_d = conflict_cnt_q;
        if (both_req && conflict_cnt_q != 8'hFF) begin
            conflict_cnt_d = conflict_cnt_q + 8'd1;
        end

        c_rvalid_d = c_win && (c_op == MEM_READ);
        e_rvalid_d = e_win && (e_op == MEM_READ);
        c_rdata_d  = c_rvalid_d ? mem_rdata : c_rdata_q;
        e_rdata_d  = e_rvalid_d ? mem_rdata : e_rdata_q;
    end

`ifdef MEM_ARB_LOCK_EN
    // Lock run length: counts consecutive locked ext grants, holds at MAX_LOCK.
    always_comb begin
        lock_cnt_d = '0;
        if (e_win && e_lock && e_req) begin
            lock_cnt_d = (lock_cnt_q < MAX_LOCK_V) ? lock_cnt_q + 1'b1 : lock_cnt_q;
        end
    end

    // Lock counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`endif

    // State registers; reset cancels any pending read return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q         <= LAST_RST;
            conflict_cnt_q <= 8'd0;
            c_rvalid_q     <= 1'b0;
            e_rvalid_q     <= 1'b0;
            c_rdata_q      <= '0;
            e_rdata_q      <= '0;
        end else begin
            last_q         <= last_d;
            conflict_cnt_q <= conflict_cnt_d;
            c_rvalid_q     <= c_rvalid_d;
            e_rvalid_q     <= e_rvalid_d;
            c_rdata_q      <= c_rdata_d;
            e_rdata_q      <= e_rdata_d;
        end
    end

    assign c_gnt        = c_win;
    assign e_gnt        = e_win;
    assign c_stall      = c_req & ~c_win;
    assign c_rvalid     = c_rvalid_q;
    assign e_rvalid     = e_rvalid_q;
    assign c_rdata      = c_rdata_q;
    assign e_rdata      = e_rdata_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 256-byte memory.
module tb_mem_port_arbiter;

    localparam logic [1:0] OP_I = 2'b00;
    localparam logic [1:0] OP_R = 2'b01;
    localparam logic [1:0] OP_W = 2'b10;
    localparam logic [1:0] OP_X = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       c_req, e_req;
    logic [1:0] c_op, e_op;
    logic [7:0] c_addr, e_addr, c_wdata, e_wdata;
    logic       c_gnt, e_gnt, c_rvalid, e_rvalid, c_stall;
    logic [7:0] c_rdata, e_rdata, conflict_cnt;
    logic [1:0] mem_op;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_LOCK_EN
    logic       e_lock;
`endif

    logic [7:0] mem [256];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_op(c_op), .c_addr(c_addr), .c_wdata(c_wdata),
        .e_req(e_req), .e_op(e_op), .e_addr(e_addr), .e_wdata(e_wdata),
`ifdef MEM_ARB_LOCK_EN
        .e_lock(e_lock),
`endif
        .c_gnt(c_gnt), .e_gnt(e_gnt),
        .c_rvalid(c_rvalid), .e_rvalid(e_rvalid),
        .c_rdata(c_rdata), .e_rdata(e_rdata),
        .c_stall(c_stall), .conflict_cnt(conflict_cnt),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory manager model: combinational read, write at the clock edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_op == OP_W) mem[mem_addr] <= mem_wdata;
    end

    typedef struct {
        logic creq; logic [1:0] cop; logic [7:0] caddr; logic [7:0] cwd;
        logic ereq; logic [1:0] eop; logic [7:0] eaddr; logic [7:0] ewd;
        logic cg; logic eg; logic st; logic [1:0] mop; logic [7:0] ma; logic [7:0] mw;
        logic crv; logic [7:0] crd; logic erv; logic [7:0] erd; logic [7:0] cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic [1:0] co, input logic [7:0] ca, input logic [7:0] cw,
                         input logic er, input logic [1:0] eo, input logic [7:0] ea, input logic [7:0] ew);
        c_req = cr; c_op = co; c_addr = ca; c_wdata = cw;
        e_req = er; e_op = eo; e_addr = ea; e_wdata = ew;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, OP_I, 8'h00, 8'h00, 0, OP_I, 8'h00, 8'h00);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
`ifdef MEM_ARB_LOCK_EN
        e_lock = 1'b0;
`endif
        drive(0, OP_I, 8'h00, 8'h00, 0, OP_I, 8'h00, 8'h00);

        //            creq cop   caddr  cwd    ereq eop   eaddr  ewd    cg eg st mop   ma     mw     crv crd    erv erd    cnt
        vecs[0]  = '{0, OP_I, 8'h00, 8'h00, 0, OP_I, 8'h00, 8'h00, 0, 0, 0, OP_I, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 8'd0};
        vecs[1]  = '{1, OP_W, 8'h10, 8'h2A, 0, OP_I, 8'h00, 8'h00, 1, 0, 0, OP_W, 8'h10, 8'h2A, 0, 8'h00, 0, 8'h00, 8'd0};
        vecs[2]  = '{1, OP_R, 8'h10, 8'h00, 0, OP_I, 8'h00, 8'h00, 1, 0, 0, OP_R, 8'h10, 8'h00, 0, 8'h00, 0, 8'h00, 8'd0};
        vecs[3]  = '{1, OP_R, 8'h03, 8'h00, 1, OP_W, 8'h03, 8'h55, 0, 1, 1, OP_W, 8'h03, 8'h55, 1, 8'h2A, 0, 8'h00, 8'd0};
        vecs[4]  = '{1, OP_R, 8'h03, 8'h00, 0, OP_I, 8'h00, 8'h00, 1, 0, 0, OP_R, 8'h03, 8'h00, 0, 8'h2A, 0, 8'h00, 8'd1};
        vecs[5]  = '{0, OP_I, 8'h00, 8'h00, 1, OP_R, 8'h03, 8'h00, 0, 1, 0, OP_R, 8'h03, 8'h00, 1, 8'h55, 0, 8'h00, 8'd1};
        vecs[6]  = '{1, OP_R, 8'h10, 8'h00, 1, OP_R, 8'h10, 8'h00, 1, 0, 0, OP_R, 8'h10, 8'h00, 0, 8'h55, 1, 8'h55, 8'd1};
        vecs[7]  = '{1, OP_W, 8'h10, 8'h77, 1, OP_R, 8'h10, 8'h00, 0, 1, 1, OP_R, 8'h10, 8'h00, 1, 8'h2A, 0, 8'h55, 8'd2};
        vecs[8]  = '{1, OP_W, 8'h10, 8'h77, 0, OP_I, 8'h00, 8'h00, 1, 0, 0, OP_W, 8'h10, 8'h77, 0, 8'h2A, 1, 8'h2A, 8'd3};
        vecs[9]  = '{1, OP_X, 8'h10, 8'h99, 0, OP_I, 8'h00, 8'h00, 1, 0, 0, OP_I, 8'h10, 8'h99, 0, 8'h2A, 0, 8'h2A, 8'd3};
        vecs[10] = '{1, OP_R, 8'h10, 8'h00, 0, OP_I, 8'h00, 8'h00, 1, 0, 0, OP_R, 8'h10, 8'h00, 0, 8'h2A, 0, 8'h2A, 8'd3};
        vecs[11] = '{0, OP_I, 8'h00, 8'h00, 1, OP_X, 8'h05, 8'h44, 0, 1, 0, OP_I, 8'h05, 8'h44, 1, 8'h77, 0, 8'h2A, 8'd3};
        vecs[12] = '{0, OP_I, 8'h00, 8'h00, 0, OP_I, 8'h00, 8'h00, 0, 0, 0, OP_I, 8'h00, 8'h00, 0, 8'h77, 0, 8'h2A, 8'd3};

        // Outputs under reset
        #2;
        check("rst_c_gnt", 8'(c_gnt), 8'h0);
        check("rst_mem_op", 8'(mem_op), 8'(OP_I));
        check("rst_cnt", conflict_cnt, 8'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table: single requester, cross-port ordering, no-ops, contention
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].creq, vecs[i].cop, vecs[i].caddr, vecs[i].cwd,
                  vecs[i].ereq, vecs[i].eop, vecs[i].eaddr, vecs[i].ewd);
            #2;
            check($sformatf("v%0d_c_gnt", i), 8'(c_gnt), 8'(vecs[i].cg));
            check($sformatf("v%0d_e_gnt", i), 8'(e_gnt), 8'(vecs[i].eg));
            check($sformatf("v%0d_c_stall", i), 8'(c_stall), 8'(vecs[i].st));
            check($sformatf("v%0d_mem_op", i), 8'(mem_op), 8'(vecs[i].mop));
            check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].ma);
            check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].mw);
            check($sformatf("v%0d_c_rvalid", i), 8'(c_rvalid), 8'(vecs[i].crv));
            check($sformatf("v%0d_c_rdata", i), c_rdata, vecs[i].crd);
            check($sformatf("v%0d_e_rvalid", i), 8'(e_rvalid), 8'(vecs[i].erv));
            check($sformatf("v%0d_e_rdata", i), e_rdata, vecs[i].erd);
            check($sformatf("v%0d_cnt", i), conflict_cnt, vecs[i].cnt);
        end

        // Async reset mid-cycle with a read return pending
        @(negedge clk);
        drive(1, OP_R, 8'h10, 8'h00, 0, OP_I, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        check("pre_rst_c_rvalid", 8'(c_rvalid), 8'h1);
        reset = 1'b1;
        #1;
        check("arst_c_rvalid", 8'(c_rvalid), 8'h0);
        check("arst_c_rdata", c_rdata, 8'h00);
        check("arst_c_gnt", 8'(c_gnt), 8'h0);
        check("arst_mem_op", 8'(mem_op), 8'(OP_I));
        check("arst_cnt", conflict_cnt, 8'h0);
        @(negedge clk);
        drive(0, OP_I, 8'h00, 8'h00, 0, OP_I, 8'h00, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Six contended cycles after reset: C,E,C,E,C,E
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(1, OP_R, 8'h10, 8'h00, 1, OP_R, 8'h03, 8'h00);
            #2;
            check($sformatf("alt%0d_c_gnt", i), 8'(c_gnt), (i % 2 == 0) ? 8'h1 : 8'h0);
            check($sformatf("alt%0d_e_gnt", i), 8'(e_gnt), (i % 2 == 0) ? 8'h0 : 8'h1);
            check($sformatf("alt%0d_c_stall", i), 8'(c_stall), (i % 2 == 0) ? 8'h0 : 8'h1);
        end
        @(negedge clk);
        drive(0, OP_I, 8'h00, 8'h00, 0, OP_I, 8'h00, 8'h00);
        #2;
        check("alt_cnt", conflict_cnt, 8'd6);

        // Saturation: 300 more contended cycles
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive(1, OP_I, 8'h00, 8'h00, 1, OP_I, 8'h00, 8'h00);
            if (i == 248) begin
                #2;
                check("cnt_254", conflict_cnt, 8'd254);
            end
        end
        @(negedge clk);
        drive(0, OP_I, 8'h00, 8'h00, 0, OP_I, 8'h00, 8'h00);
        #2;
        check("cnt_sat", conflict_cnt, 8'd255);

`ifdef MEM_ARB_LOCK_EN
        // Locked ext: C (pointer), E x4 locked, forced C, E resumes
        do_reset();
        e_lock = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(1, OP_R, 8'h10, 8'h00, 1, OP_R, 8'h03, 8'h00);
            #2;
            check($sformatf("lock%0d_c_gnt", i), 8'(c_gnt), (i == 0 || i == 5) ? 8'h1 : 8'h0);
            check($sformatf("lock%0d_e_gnt", i), 8'(e_gnt), (i == 0 || i == 5) ? 8'h0 : 8'h1);
        end
        e_lock = 1'b0;
`else
        // Without lock support contention alternates strictly from reset
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(1, OP_R, 8'h10, 8'h00, 1, OP_R, 8'h03, 8'h00);
            #2;
            check($sformatf("rr%0d_c_gnt", i), 8'(c_gnt), (i % 2 == 0) ? 8'h1 : 8'h0);
            check($sformatf("rr%0d_e_gnt", i), 8'(e_gnt), (i % 2 == 0) ? 8'h0 : 8'h1);
        end
`endif
        @(negedge clk);
        drive(0, OP_I, 8'h00, 8'h00, 0, OP_I, 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
